// File: rtl/reu_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : reu_xfer
//  Description : REU DMA byte-transfer engine (stash, fetch, swap, verify),
//                clocked on the falling edge of PHI2.
//  Revision    : 1.0 - initial release
// ============================================================================
module reu_xfer (
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       BA,
    input  logic [7:0] CD,
    input  logic [7:0] RD,
    output logic       DMA,
    output logic       CRnW,
    output logic [7:0] CDOut,
    output logic       RWE,
    output logic       ROE,
    output logic [7:0] RDOut,
    output logic       IncCA,
    output logic       IncREUA,
    output logic       DecLen,
    output logic       XferEnd,
    output logic       SetEndOfBlock,
    output logic       SetVerifyErr,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_XFER  = 3'd2,
        S_SWAPW = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] C_STASH  = 2'b00;
    localparam logic [1:0] C_FETCH  = 2'b01;
    localparam logic [1:0] C_SWAP   = 2'b10;
    localparam logic [1:0] C_VERIFY = 2'b11;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_type;
    logic [7:0] r_cbuf;
    logic [7:0] r_rbuf;
    logic       w_byteDone;
    logic       w_mismatch;
    logic       w_latchSwap;

    always_ff @(negedge PHI2) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_type  <= C_STASH;
            r_cbuf  <= 8'h00;
            r_rbuf  <= 8'h00;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && Execute)
                r_type <= XferType;
            if (w_latchSwap) begin
                r_cbuf <= CD;
                r_rbuf <= RD;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_byteDone    = 1'b0;
        w_mismatch    = 1'b0;
        w_latchSwap   = 1'b0;
        DMA           = 1'b0;
        CRnW          = 1'b1;
        CDOut         = 8'h00;
        RWE           = 1'b0;
        ROE           = 1'b0;
        RDOut         = 8'h00;
        IncCA         = 1'b0;
        IncREUA       = 1'b0;
        DecLen        = 1'b0;
        XferEnd       = 1'b0;
        SetEndOfBlock = 1'b0;
        SetVerifyErr  = 1'b0;
        Busy          = 1'b0;

        // Everything is gated by Reset so no strobe escapes in the reset cycle.
        if (!Reset) begin
            Busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (Execute)
                        w_nextState = S_START;
                end
                S_START: begin
                    DMA = 1'b1;
                    if (BA)
                        w_nextState = S_XFER;
                end
                S_XFER: begin
                    DMA = 1'b1;
                    if (BA) begin
                        case (r_type)
                            C_STASH: begin
                                RWE        = 1'b1;
                                RDOut      = CD;
                                w_byteDone = 1'b1;
                            end
                            C_FETCH: begin
                                ROE        = 1'b1;
                                CRnW       = 1'b0;
                                CDOut      = RD;
                                w_byteDone = 1'b1;
                            end
                            C_SWAP: begin
                                ROE         = 1'b1;
                                w_latchSwap = 1'b1;
                                w_nextState = S_SWAPW;
                            end
                            default: begin
                                ROE        = 1'b1;
                                w_mismatch = (CD != RD);
                                w_byteDone = 1'b1;
                            end
                        endcase
                    end
                end
                S_SWAPW: begin
                    DMA = 1'b1;
                    if (BA) begin
                        CRnW       = 1'b0;
                        CDOut      = r_rbuf;
                        RWE        = 1'b1;
                        RDOut      = r_cbuf;
                        w_byteDone = 1'b1;
                    end
                end
                S_DONE: begin
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase

            if (w_byteDone) begin
                IncCA       = 1'b1;
                IncREUA     = 1'b1;
                DecLen      = 1'b1;
                w_nextState = S_XFER;
                if (Length1 || w_mismatch) begin
                    XferEnd       = 1'b1;
                    SetEndOfBlock = Length1;
                    SetVerifyErr  = w_mismatch;
                    w_nextState   = S_DONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reu_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reu_xfer
//  Description : Directed self-checking bench for reu_xfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reu_xfer;

    logic       PHI2 = 1'b1;
    logic       Reset, Execute, Length1, BA;
    logic [1:0] XferType;
    logic [7:0] CD, RD;
    logic       DMA, CRnW, RWE, ROE, IncCA, IncREUA, DecLen;
    logic       XferEnd, SetEndOfBlock, SetVerifyErr, Busy;
    logic [7:0] CDOut, RDOut;

    int nChecks = 0;
    int nFails  = 0;

    always #5 PHI2 = ~PHI2;

    reu_xfer dut (
        .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .XferType(XferType),
        .Length1(Length1), .BA(BA), .CD(CD), .RD(RD),
        .DMA(DMA), .CRnW(CRnW), .CDOut(CDOut), .RWE(RWE), .ROE(ROE), .RDOut(RDOut),
        .IncCA(IncCA), .IncREUA(IncREUA), .DecLen(DecLen), .XferEnd(XferEnd),
        .SetEndOfBlock(SetEndOfBlock), .SetVerifyErr(SetVerifyErr), .Busy(Busy)
    );

    // {DMA,CRnW,RWE,ROE,IncCA,IncREUA,DecLen,XferEnd,SetEndOfBlock,SetVerifyErr,Busy}
    logic [10:0] w_ctl;
    assign w_ctl = {DMA, CRnW, RWE, ROE, IncCA, IncREUA, DecLen,
                    XferEnd, SetEndOfBlock, SetVerifyErr, Busy};

    localparam logic [10:0] K_IDLE    = 11'b0_1_0_0_000_000_0;
    localparam logic [10:0] K_HOLD    = 11'b1_1_0_0_000_000_1;
    localparam logic [10:0] K_DONE    = 11'b0_1_0_0_000_000_1;
    localparam logic [10:0] K_STASH   = 11'b1_1_1_0_111_000_1;
    localparam logic [10:0] K_STASHL  = 11'b1_1_1_0_111_110_1;
    localparam logic [10:0] K_FETCH   = 11'b1_0_0_1_111_000_1;
    localparam logic [10:0] K_FETCHL  = 11'b1_0_0_1_111_110_1;
    localparam logic [10:0] K_SWAPR   = 11'b1_1_0_1_000_000_1;
    localparam logic [10:0] K_SWAPWL  = 11'b1_0_1_0_111_110_1;
    localparam logic [10:0] K_VFY     = 11'b1_1_0_1_111_000_1;
    localparam logic [10:0] K_VFYERR  = 11'b1_1_0_1_111_101_1;
    localparam logic [10:0] K_VFYERRL = 11'b1_1_0_1_111_111_1;

    typedef struct packed {
        logic        rst;
        logic        exe;
        logic [1:0]  xt;
        logic        ba;
        logic        len1;
        logic [7:0]  cd;
        logic [7:0]  rd;
        logic [10:0] ctl;
        logic [7:0]  cdo;
        logic [7:0]  rdo;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] t,
                                input logic b, input logic l, input logic [7:0] c,
                                input logic [7:0] d, input logic [10:0] k,
                                input logic [7:0] co, input logic [7:0] ro);
        vec_t v;
        v = '{rst: r, exe: e, xt: t, ba: b, len1: l, cd: c, rd: d, ctl: k, cdo: co, rdo: ro};
        return v;
    endfunction

    task automatic applyInputs(input vec_t v);
        Reset    = v.rst;
        Execute  = v.exe;
        XferType = v.xt;
        BA       = v.ba;
        Length1  = v.len1;
        CD       = v.cd;
        RD       = v.rd;
    endtask

    task automatic test_reset();
        vec_t v [3];
        v[0] = mk(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE, 8'h00, 8'h00);
        v[1] = mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 8'h00, K_IDLE, 8'h00, 8'h00);
        v[2] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE, 8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL reset[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            @(negedge PHI2); #1;
        end
    endtask

    // A second Execute during the transfer (and in DONE) must be ignored.
    task automatic test_stash();
        vec_t v [7];
        v[0] = mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        v[1] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,   8'h00, 8'h00);
        v[2] = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h11, 8'h99, K_STASH,  8'h00, 8'h11);
        v[3] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h22, 8'h99, K_STASH,  8'h00, 8'h22);
        v[4] = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'h33, 8'h99, K_STASHL, 8'h00, 8'h33);
        v[5] = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, K_DONE,   8'h00, 8'h00);
        v[6] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL stash[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            if (v[i].ctl[8]) begin
                nChecks++;
                if (RDOut !== v[i].rdo) begin
                    nFails++;
                    $display("FAIL stash[%0d] RDOut: got %h expected %h", i, RDOut, v[i].rdo);
                end
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_fetch_stall();
        vec_t v [9];
        v[0] = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        v[1] = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, K_HOLD,   8'h00, 8'h00);
        v[2] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,   8'h00, 8'h00);
        v[3] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'hA1, K_FETCH,  8'hA1, 8'h00);
        v[4] = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'hA1, K_HOLD,   8'h00, 8'h00);
        v[5] = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 8'hB2, K_HOLD,   8'h00, 8'h00);
        v[6] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 8'hB2, K_FETCHL, 8'hB2, 8'h00);
        v[7] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_DONE,   8'h00, 8'h00);
        v[8] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL fetch[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            if (!v[i].ctl[9]) begin
                nChecks++;
                if (CDOut !== v[i].cdo) begin
                    nFails++;
                    $display("FAIL fetch[%0d] CDOut: got %h expected %h", i, CDOut, v[i].cdo);
                end
            end
            @(negedge PHI2); #1;
        end
    endtask

    // Bus values change in the write cycle so only the latched buffers can supply data.
    task automatic test_swap();
        vec_t v [6];
        v[0] = mk(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        v[1] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,   8'h00, 8'h00);
        v[2] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'hAA, 8'h55, K_SWAPR,  8'h00, 8'h00);
        v[3] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h0F, 8'hF0, K_SWAPWL, 8'h55, 8'hAA);
        v[4] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_DONE,   8'h00, 8'h00);
        v[5] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,   8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL swap[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            if (!v[i].ctl[9]) begin
                nChecks++;
                if (CDOut !== v[i].cdo) begin
                    nFails++;
                    $display("FAIL swap[%0d] CDOut: got %h expected %h", i, CDOut, v[i].cdo);
                end
            end
            if (v[i].ctl[8]) begin
                nChecks++;
                if (RDOut !== v[i].rdo) begin
                    nFails++;
                    $display("FAIL swap[%0d] RDOut: got %h expected %h", i, RDOut, v[i].rdo);
                end
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_verify();
        vec_t v [11];
        v[0]  = mk(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,    8'h00, 8'h00);
        v[1]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,    8'h00, 8'h00);
        v[2]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h10, 8'h10, K_VFY,     8'h00, 8'h00);
        v[3]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h20, 8'h21, K_VFYERR,  8'h00, 8'h00);
        v[4]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h30, 8'h31, K_DONE,    8'h00, 8'h00);
        v[5]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,    8'h00, 8'h00);
        v[6]  = mk(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,    8'h00, 8'h00);
        v[7]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,    8'h00, 8'h00);
        v[8]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h5A, 8'hA5, K_VFYERRL, 8'h00, 8'h00);
        v[9]  = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_DONE,    8'h00, 8'h00);
        v[10] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,    8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL verify[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_reset_mid();
        vec_t v [6];
        v[0] = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, K_IDLE,  8'h00, 8'h00);
        v[1] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, K_HOLD,  8'h00, 8'h00);
        v[2] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h77, K_FETCH, 8'h77, 8'h00);
        v[3] = mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h88, K_IDLE,  8'h00, 8'h00);
        v[4] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h99, K_IDLE,  8'h00, 8'h00);
        v[5] = mk(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 8'h99, K_IDLE,  8'h00, 8'h00);
        foreach (v[i]) begin
            applyInputs(v[i]);
            @(posedge PHI2);
            nChecks++;
            if (w_ctl !== v[i].ctl) begin
                nFails++;
                $display("FAIL reset_mid[%0d] ctl: got %b expected %b", i, w_ctl, v[i].ctl);
            end
            if (!v[i].ctl[9]) begin
                nChecks++;
                if (CDOut !== v[i].cdo) begin
                    nFails++;
                    $display("FAIL reset_mid[%0d] CDOut: got %h expected %h", i, CDOut, v[i].cdo);
                end
            end
            @(negedge PHI2); #1;
        end
    endtask

    initial begin
        Reset = 1'b1; Execute = 1'b0; XferType = 2'b00;
        BA = 1'b1; Length1 = 1'b0; CD = 8'h00; RD = 8'h00;
        #1;
        test_reset();
        test_stash();
        test_fetch_stall();
        test_swap();
        test_verify();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/reu_xfer.md
REU_XFER -- requirements
Module: reu_xfer

Interface
REQ-001 PHI2  in  1  system clock; all state updates on the falling edge of PHI2.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Execute  in  1  one-cycle transfer start request from the register block.
REQ-004 XferType  in  2  transfer type: 00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify.
REQ-005 Length1  in  1  high when the remaining length equals 1, meaning the current byte is the last.
REQ-006 BA  in  1  C64 bus available; low stalls the DMA.
REQ-007 CD  in  8  C64 data bus read value.
REQ-008 RD  in  8  REU RAM read data.
REQ-009 DMA  out  1  C64 bus request; high while the block owns the bus.
REQ-010 CRnW  out  1  C64 bus direction: 1 = read C64, 0 = write C64.
REQ-011 CDOut  out  8  data driven onto the C64 bus when CRnW=0.
REQ-012 RWE / ROE  out  1 each  REU RAM write enable and output enable.
REQ-013 RDOut  out  8  REU RAM write data.
REQ-014 IncCA, IncREUA, DecLen  out  1 each  counter strobes to the register block.
REQ-015 XferEnd, SetEndOfBlock, SetVerifyErr  out  1 each  completion and status strobes.
REQ-016 Busy  out  1  high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, START, XFER, SWAPW and DONE.
REQ-018 IDLE SHALL go to START when Execute=1 at a falling edge, latching XferType; DMA SHALL go high on that edge.
REQ-019 START SHALL go to XFER at the first falling edge with BA=1 and SHALL otherwise hold.
REQ-020 One byte access SHALL occur per PHI2 cycle while in XFER or SWAPW with BA=1.
REQ-021 Whenever BA=0, the state SHALL hold, all strobes and RWE SHALL be low, and CRnW SHALL be 1.
REQ-022 Stash (XFER): CRnW=1, RWE=1, RDOut=CD; IncCA, IncREUA and DecLen SHALL be high.
REQ-023 Fetch (XFER): ROE=1, CRnW=0, CDOut=RD; IncCA, IncREUA and DecLen SHALL be high.
REQ-024 Swap, XFER cycle: read both sides, latching CD into cbuf and RD into rbuf, with no strobes; the state SHALL then go to SWAPW.
REQ-025 Swap, SWAPW cycle: CRnW=0, CDOut=rbuf, RWE=1, RDOut=cbuf; IncCA, IncREUA and DecLen SHALL be high; the state SHALL then return to XFER, or go to DONE if this was the last byte.
REQ-026 Verify (XFER): CRnW=1, ROE=1, compare CD to RD; IncCA, IncREUA and DecLen SHALL be high.
REQ-027 A verify mismatch SHALL pulse SetVerifyErr and XferEnd in that cycle, and the state SHALL go to DONE.
REQ-028 Last byte: in the byte-completing cycle with Length1=1, SetEndOfBlock and XferEnd SHALL pulse, and the state SHALL go to DONE.
REQ-029 On a verify mismatch on the last byte, SetEndOfBlock and SetVerifyErr SHALL both pulse.
REQ-030 All strobes SHALL be combinational decodes of state, XferType, BA, Length1 and the compare result; each SHALL be one cycle wide per byte.
REQ-031 DONE SHALL deassert DMA and go to IDLE at the next edge, so DMA is low one cycle after XferEnd.
REQ-032 Execute SHALL be ignored when the state is not IDLE.
REQ-033 Length0 (65536 bytes) SHALL need no special handling: the transfer runs until Length1 is asserted.
REQ-034 The latency from Execute to the first byte access SHALL be 2 cycles when BA=1 throughout.

Reset
REQ-035 Reset=1 at a falling edge SHALL force IDLE, clear cbuf and rbuf, drive DMA=0, CRnW=1, RWE=0 and ROE=0, and drive all strobes and Busy low, including mid-transfer.
REQ-036 No strobe SHALL be generated in the cycle in which Reset is high.

Verification
REQ-037 Stash, Length 3, BA=1, CD=11,22,33 -> RWE pulses writing 11,22,33; 3 IncCA/IncREUA/DecLen pulses; XferEnd and SetEndOfBlock on byte 3; DMA low 1 cycle later.
REQ-038 Fetch, Length 2, BA low for 2 cycles between bytes -> the state holds, no strobes are issued while BA is low, and exactly 2 DecLen pulses occur.
REQ-039 Swap, Length 1, CD=AA, RD=55 -> XFER then SWAPW; the C64 receives 55 and the REU receives AA; one DecLen pulse; XferEnd asserted in the SWAPW cycle.
REQ-040 Verify, Length 4, mismatch on byte 2 -> SetVerifyErr and XferEnd on byte 2; no SetEndOfBlock; exactly 2 DecLen pulses.
REQ-041 Reset asserted mid-fetch after byte 1 of 5 -> IDLE next edge, DMA=0, no further strobes.
REQ-042 Execute pulsed again during a stash -> ignored; the transfer completes with its original length and type.
